axi_lite_imem_loader: RTL and testbench
=======================================

Name: axi_lite_imem_loader

Overview:
- AXI4-Lite slave that loads programs into the single-cycle core's instruction memory.
- Converts host write transactions into one-cycle pulses on the instruction_write / instruction_addr / instruction_data port.
- Exposes a control register that holds the core in reset while loading, plus a read-only count of words loaded.
- Sits between the AXI4-Lite interconnect and the instruction memory write port.

Parameters:
- ADDR_W, 12, AXI address width (byte addresses).
- IMEM_DEPTH, 256, instruction words; word index is awaddr[9:2].
- CTRL_ADDR, 12'h400, control register (RW).
- COUNT_ADDR, 12'h404, load-count register (RO).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  response valid
- s_axi_bready  in  1  response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read valid
- s_axi_rready  in  1  read ready
- instruction_write  out  1  one-cycle write strobe to instruction memory
- instruction_addr  out  8  word index
- instruction_data  out  32  instruction word
- core_hold  out  1  holds the core in reset (CTRL bit0)

Behaviour:
- Reset: single clock, reset sampled on rising clk only; no asynchronous reset path.
  - While reset_n=0, all of the following are 0: readies, valids, instruction_write, instruction_addr, instruction_data, bresp, rresp, rdata, load_count.
  - core_hold=1 during reset.
  - awready, wready, arready rise on the first cycle after reset release.
- Write path, collect phase:
  - AW and W are captured independently into holding registers.
  - awready=1 iff no AW held and no B pending; wready likewise for W.
  - Either handshake may precede the other by any number of cycles.
  - Same-cycle AW and W handshakes are legal.
- Write path, state machine WR_COLLECT -> WR_EXEC -> WR_RESP:
  - WR_COLLECT: advance to WR_EXEC on the edge where both AW and W are held.
  - WR_EXEC, one cycle:
    - Decode the request.
    - Pulse instruction_write if valid.
    - Assert bvalid with bresp.
    - Enter WR_RESP.
  - WR_RESP: hold bvalid/bresp stable until bready=1.
    - bvalid & bready -> WR_COLLECT; readies reassert the next cycle.
  - Latency: final capture edge N -> instruction_write high and bvalid high during cycle N+1.
- Write decode, bresp OKAY=2'b00, SLVERR=2'b10:
  - Address < 4*IMEM_DEPTH with wstrb=4'hF:
    - instruction_write=1, instruction_addr=awaddr[9:2], instruction_data=wdata, OKAY.
    - load_count += 1, saturating at 511 (9-bit).
  - Address = CTRL_ADDR with wstrb[0]=1: core_hold <= wdata[0], OKAY.
  - Partial strobe in the instruction region: no write, SLVERR.
  - Write to COUNT_ADDR: SLVERR.
  - Any other address: SLVERR.
  - awaddr[1:0] is ignored.
  - instruction_addr/instruction_data hold their last value when not strobed.
- Read path:
  - arready=1 iff rvalid=0.
  - AR handshake at edge N -> rvalid=1 during cycle N+1; hold stable until rready.
  - CTRL_ADDR returns {31'b0, core_hold}, OKAY.
  - COUNT_ADDR returns {23'b0, load_count}, OKAY.
  - Instruction region returns rdata=0 with SLVERR (memory has no readback port).
  - Any other address returns rdata=0 with SLVERR.
- Concurrency:
  - Read and write paths are fully independent.
  - A read and a write of CTRL in the same cycle: the read returns the pre-write value.
  - The same rule applies to COUNT versus an instruction write.
- Reset mid-transaction: held AW/W and pending B/R are discarded; no instruction_write is issued.
- Pulse width: instruction_write is never high for two consecutive cycles.

Decomposition:
- Shared package axi_lite_pkg holds:
  - RESP_OKAY, RESP_SLVERR
  - CTRL_ADDR, COUNT_ADDR
  - IMEM_DEPTH
  - write-FSM state encoding
- No sub-module: both channels fit in one module.
- The core top instantiates this loader next to the instruction memory and drives the core's reset with reset_n & ~core_hold.

Test Plan:
1. Reset, then AW 0x010 / W 0xDEADBEEF / strb F in the same cycle -> next cycle instruction_write=1, addr=8'h04, data=0xDEADBEEF, bvalid with OKAY; COUNT reads 1.
2. W 0x00000013 presented 3 cycles before AW 0x3FC -> exactly one pulse at addr 8'hFF; awready=wready=0 until B accepted.
3. bready held low 5 cycles -> bvalid/bresp stable for 5 cycles; a second AW is not accepted until B completes.
4. Write 0x0 to CTRL -> core_hold falls, OKAY; CTRL read returns 0; a read of CTRL in the same cycle as a write of 1 returns 0.
5. strb 4'h3 to 0x020, write to 0x404, write to 0x800, read 0x020 -> no instruction_write; each returns SLVERR; read rdata=0.
6. reset_n low while AW is held and W is absent -> no pulse; after release, readies=1, core_hold=1, COUNT=0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared constants and write-FSM encoding for the AXI4-Lite instruction-memory loader
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int IMEM_DEPTH = 256;
  localparam int CTRL_ADDR  = 'h400;
  localparam int COUNT_ADDR = 'h404;
  typedef enum logic [1:0] {WR_COLLECT, WR_EXEC, WR_RESP} wr_state_t;
endpackage

// File: rtl/axi_lite_imem_loader.sv
// axi_lite_imem_loader: AXI4-Lite slave turning host writes into instruction-memory write pulses
//   clk, reset_n          : clock, synchronous active-low reset
//   s_axi_aw*/w*/b*       : write channels; instruction region, CTRL (RW) and COUNT (RO)
//   s_axi_ar*/r*          : read channels; CTRL and COUNT only, everything else SLVERR
//   instruction_write/addr/data : one-cycle write strobe to the instruction memory
//   core_hold             : CTRL bit0, keeps the core in reset while loading
module axi_lite_imem_loader
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              instruction_write,
  output logic [7:0]        instruction_addr,
  output logic [31:0]       instruction_data,
  output logic              core_hold
);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'(CTRL_ADDR);
  localparam logic [ADDR_W-1:0] COUNT_A   = ADDR_W'(COUNT_ADDR);
  localparam logic [ADDR_W-1:0] IMEM_END  = ADDR_W'(4 * IMEM_DEPTH);

  wr_state_t         state;
  logic              live;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [8:0]        load_count;
  logic              aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0] a;
  logic [31:0]       d;
  logic [3:0]        s;
  logic              imem_ok, ctrl_ok, r_ctrl, r_count;

  // held AW/W stay set until the B handshake, which also covers "no B pending"
  assign s_axi_awready = live & ~aw_held;
  assign s_axi_wready  = live & ~w_held;
  assign s_axi_arready = live & ~s_axi_rvalid;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // decode on the capture edge so the pulse and bvalid land in the very next cycle
  assign a = aw_hs ? s_axi_awaddr : aw_addr;
  assign d = w_hs ? s_axi_wdata : w_data;
  assign s = w_hs ? s_axi_wstrb : w_strb;
  assign imem_ok = (a < IMEM_END) & (s == 4'hF);
  assign ctrl_ok = ((a & WORD_MASK) == CTRL_A) & s[0];
  assign r_ctrl  = (s_axi_araddr & WORD_MASK) == CTRL_A;
  assign r_count = (s_axi_araddr & WORD_MASK) == COUNT_A;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= WR_COLLECT;
      live              <= 1'b0;
      aw_held           <= 1'b0;
      w_held            <= 1'b0;
      aw_addr           <= '0;
      w_data            <= '0;
      w_strb            <= '0;
      load_count        <= '0;
      core_hold         <= 1'b1;
      s_axi_bvalid      <= 1'b0;
      s_axi_bresp       <= RESP_OKAY;
      s_axi_rvalid      <= 1'b0;
      s_axi_rdata       <= '0;
      s_axi_rresp       <= RESP_OKAY;
      instruction_write <= 1'b0;
      instruction_addr  <= '0;
      instruction_data  <= '0;
    end else begin
      live              <= 1'b1;
      instruction_write <= 1'b0;
      // read samples core_hold/load_count before any same-edge write updates them
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= r_ctrl ? {31'b0, core_hold} : r_count ? {23'b0, load_count} : 32'b0;
        s_axi_rresp  <= (r_ctrl | r_count) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      if (state == WR_COLLECT) begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_addr <= s_axi_awaddr;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= s_axi_wdata;
          w_strb <= s_axi_wstrb;
        end
        if ((aw_held | aw_hs) & (w_held | w_hs)) begin
          state             <= WR_EXEC;
          instruction_write <= imem_ok;
          s_axi_bvalid      <= 1'b1;
          s_axi_bresp       <= (imem_ok | ctrl_ok) ? RESP_OKAY : RESP_SLVERR;
          if (imem_ok) begin
            instruction_addr <= a[9:2];
            instruction_data <= d;
            load_count       <= load_count + {8'b0, ~&load_count};
          end
          if (ctrl_ok) core_hold <= d[0];
        end
      end else if (s_axi_bready) begin
        state        <= WR_COLLECT;
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end else begin
        state <= WR_RESP;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_imem_loader.sv
// tb_axi_lite_imem_loader: randomized bench with a transaction-level reference model checked every cycle
module tb_axi_lite_imem_loader;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [11:0] s_axi_awaddr = 0;
  logic        s_axi_awvalid = 0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = 0;
  logic [3:0]  s_axi_wstrb = 0;
  logic        s_axi_wvalid = 0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 0;
  logic [11:0] s_axi_araddr = 0;
  logic        s_axi_arvalid = 0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 0;
  logic        instruction_write;
  logic [7:0]  instruction_addr;
  logic [31:0] instruction_data;
  logic        core_hold;

  axi_lite_imem_loader dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .instruction_write(instruction_write), .instruction_addr(instruction_addr),
    .instruction_data(instruction_data), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0]  last_ia;
  logic [31:0] last_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one transaction at a time, advanced on every rising edge
  bit          m_init, m_rst, m_live, m_aw_h, m_w_h, m_bv, m_rv, m_pulse, m_hold;
  bit          awr, wr, arr;
  logic [11:0] m_aw_a;
  logic [31:0] m_w_d, m_rd, m_id;
  logic [3:0]  m_w_s;
  logic [1:0]  m_br, m_rr;
  logic [7:0]  m_ia;
  int          m_count;

  function automatic logic [33:0] rd_model(input logic [11:0] a);
    if (a[11:2] == 10'h100) return {2'b00, 31'b0, m_hold};
    if (a[11:2] == 10'h101) return {2'b00, 32'(m_count)};
    return {2'b10, 32'b0};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_init = 1; m_rst = 1; m_live = 0; m_aw_h = 0; m_w_h = 0; m_bv = 0; m_rv = 0;
      m_pulse = 0; m_hold = 1; m_count = 0; m_br = 0; m_rr = 0; m_rd = 0; m_ia = 0; m_id = 0;
    end else begin
      awr = m_live && !m_aw_h; wr = m_live && !m_w_h; arr = m_live && !m_rv;
      m_rst = 0; m_pulse = 0;
      if (m_rv && s_axi_rready) m_rv = 0;
      if (arr && s_axi_arvalid) begin
        m_rv = 1;
        {m_rr, m_rd} = rd_model(s_axi_araddr);
      end
      if (m_bv) begin
        if (s_axi_bready) begin m_bv = 0; m_aw_h = 0; m_w_h = 0; end
      end else begin
        if (awr && s_axi_awvalid) begin m_aw_h = 1; m_aw_a = s_axi_awaddr; end
        if (wr && s_axi_wvalid) begin m_w_h = 1; m_w_d = s_axi_wdata; m_w_s = s_axi_wstrb; end
        if (m_aw_h && m_w_h) begin
          m_bv = 1; m_br = 2'b10;
          if (m_aw_a < 12'h400) begin
            if (m_w_s == 4'hF) begin
              m_pulse = 1; m_ia = m_aw_a[9:2]; m_id = m_w_d; m_br = 2'b00;
              if (m_count < 511) m_count++;
            end
          end else if (m_aw_a[11:2] == 10'h100 && m_w_s[0]) begin
            m_hold = m_w_d[0]; m_br = 2'b00;
          end
        end
      end
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("awready", s_axi_awready, m_live && !m_aw_h);
      chk("wready", s_axi_wready, m_live && !m_w_h);
      chk("arready", s_axi_arready, m_live && !m_rv);
      chk("bvalid", s_axi_bvalid, m_bv);
      if (m_bv || m_rst) chk("bresp", s_axi_bresp, m_br);
      chk("rvalid", s_axi_rvalid, m_rv);
      if (m_rv || m_rst) begin
        chk("rdata", s_axi_rdata, m_rd);
        chk("rresp", s_axi_rresp, m_rr);
      end
      chk("instruction_write", instruction_write, m_pulse);
      chk("instruction_addr", instruction_addr, m_ia);
      chk("instruction_data", instruction_data, m_id);
      chk("core_hold", core_hold, m_hold);
      if (instruction_write) begin
        pulses++; last_ia = instruction_addr; last_id = instruction_data;
      end
    end
  end

  task automatic hs_wait(input int which);
    int n = 0;
    logic r;
    forever begin
      @(negedge clk);
      r = which == 0 ? s_axi_awready : which == 1 ? s_axi_wready : s_axi_arready;
      @(posedge clk);
      if (r) break;
      if (++n > 200) begin
        checks++; errors++;
        $display("FAIL ready_timeout ch%0d: ready stayed 0, expected 1 within 200 cycles", which);
        break;
      end
    end
    #1;
  endtask

  task automatic wait_valid(input int which);
    int n = 0;
    forever begin
      @(negedge clk);
      if (which == 0 ? s_axi_bvalid : s_axi_rvalid) break;
      if (++n > 200) begin
        checks++; errors++;
        $display("FAIL valid_timeout ch%0d: valid stayed 0, expected 1 within 200 cycles", which);
        break;
      end
    end
  endtask

  task automatic send_aw(input logic [11:0] a, input int dly);
    repeat (dly) @(posedge clk);
    #1 s_axi_awaddr = a; s_axi_awvalid = 1;
    hs_wait(0);
    s_axi_awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) @(posedge clk);
    #1 s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
    hs_wait(1);
    s_axi_wvalid = 0;
  endtask

  task automatic take_b(input int dly, output logic [1:0] resp);
    wait_valid(0);
    repeat (dly) @(negedge clk);
    resp = s_axi_bresp;
    s_axi_bready = 1;
    @(posedge clk);
    #1 s_axi_bready = 0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int bd, output logic [1:0] resp);
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    take_b(bd, resp);
  endtask

  task automatic do_read(input logic [11:0] a, input int ad, input int rd,
                         output logic [31:0] data, output logic [1:0] resp);
    repeat (ad) @(posedge clk);
    #1 s_axi_araddr = a; s_axi_arvalid = 1;
    hs_wait(2);
    s_axi_arvalid = 0;
    wait_valid(1);
    repeat (rd) @(negedge clk);
    data = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1;
    @(posedge clk);
    #1 s_axi_rready = 0;
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 12'($urandom_range(0, 1023));
      3:       return 12'h400 | 12'($urandom_range(0, 3));
      4:       return 12'h404 | 12'($urandom_range(0, 3));
      default: return 12'($urandom_range(12'h408, 12'hFFF));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0]  r, r2;
    logic [31:0] d;
    int p0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;

    // same-cycle AW and W into the instruction region
    p0 = pulses;
    do_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
    chk("t1_resp", r, 2'b00);
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_addr", last_ia, 8'h04);
    chk("t1_data", last_id, 32'hDEADBEEF);
    do_read(12'h404, 0, 0, d, r);
    chk("t1_count", d, 1);
    chk("t1_count_resp", r, 2'b00);

    // W leads AW by three cycles, last word of the region
    p0 = pulses;
    do_write(12'h3FC, 32'h00000013, 4'hF, 3, 0, 0, r);
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_addr", last_ia, 8'hFF);
    chk("t2_resp", r, 2'b00);

    // B back-pressured for five cycles while a second AW waits
    fork
      do_write(12'h100, 32'h12345678, 4'hF, 0, 0, 5, r);
      begin repeat (2) @(posedge clk); send_aw(12'h104, 0); end
      begin repeat (4) @(negedge clk); chk("t3_aw_blocked", s_axi_awready, 0); end
    join
    chk("t3_resp", r, 2'b00);
    send_w(32'hCAFEF00D, 4'hF, 0);
    take_b(0, r);
    chk("t3_second_resp", r, 2'b00);
    chk("t3_second_addr", last_ia, 8'h41);

    // CTRL write/read, including a read racing a write in the same cycle
    do_write(12'h400, 32'h0, 4'hF, 0, 0, 0, r);
    chk("t4_resp", r, 2'b00);
    chk("t4_hold", core_hold, 0);
    do_read(12'h400, 0, 0, d, r);
    chk("t4_read", d, 0);
    fork
      do_write(12'h400, 32'h1, 4'h1, 0, 0, 0, r2);
      do_read(12'h400, 0, 0, d, r);
    join
    chk("t4_race_read", d, 0);
    do_read(12'h400, 0, 0, d, r);
    chk("t4_after", d, 1);

    // error cases
    p0 = pulses;
    do_write(12'h020, 32'h11111111, 4'h3, 0, 0, 0, r);
    chk("t5_partial", r, 2'b10);
    do_write(12'h404, 32'h22222222, 4'hF, 0, 0, 0, r);
    chk("t5_count_wr", r, 2'b10);
    do_write(12'h800, 32'h33333333, 4'hF, 0, 0, 0, r);
    chk("t5_other", r, 2'b10);
    do_read(12'h020, 0, 0, d, r);
    chk("t5_rd_data", d, 0);
    chk("t5_rd_resp", r, 2'b10);
    chk("t5_pulses", pulses - p0, 0);

    // randomized traffic with concurrent reads
    for (int i = 0; i < 150; i++) begin
      fork
        do_write(rand_addr(), $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
        do_read(rand_addr(), $urandom_range(0, 4), $urandom_range(0, 3), d, r2);
      join
    end

    // reset while AW is held and W never arrives
    send_aw(12'h040, 0);
    p0 = pulses;
    @(posedge clk); #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_awready", s_axi_awready, 1);
    chk("t6_wready", s_axi_wready, 1);
    chk("t6_arready", s_axi_arready, 1);
    chk("t6_hold", core_hold, 1);
    repeat (3) @(posedge clk);
    chk("t6_pulses", pulses - p0, 0);
    #1;
    do_read(12'h404, 0, 0, d, r);
    chk("t6_count", d, 0);

    // drive the load counter past saturation
    for (int i = 0; i < 515; i++) do_write(12'($urandom_range(0, 255) * 4), $urandom, 4'hF, 0, 0, 0, r);
    do_read(12'h404, 0, 0, d, r);
    chk("sat_count", d, 511);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
